// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port 256x32 data memory: one registered access per cycle.
// Optional round-robin tie-break from IDLE when DMEM_ARB_RR_EN is defined (fixed p0 priority otherwise).
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_P0 = 2'd1,
    BUSY_P1 = 2'd2
  } state_t;

  state_t              state_p1;
  state_t              state_nxt;
  logic                p0_elig;
  logic                p1_elig;
  logic [ADDR_W-1:0]   acc_addr_p1;
  logic [DATA_W-1:0]   acc_wdata_p1;
  logic                acc_we_p1;

  // A port being acked in the current cycle cannot win the closing edge,
  // which is what forces alternation when both ports keep requesting.
  assign p0_elig = p0_req && (state_p1 != BUSY_P0);
  assign p1_elig = p1_req && (state_p1 != BUSY_P1);

`ifdef DMEM_ARB_RR_EN
  logic last_p1;  // 1 = port 1 was granted most recently

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_p1 <= 1'b1;
    end else if (state_nxt == BUSY_P0) begin
      last_p1 <= 1'b0;
    end else if (state_nxt == BUSY_P1) begin
      last_p1 <= 1'b1;
    end
  end
`endif

  // ---- stage p1: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if (p0_elig && p1_elig) begin
`ifdef DMEM_ARB_RR_EN
      state_nxt = last_p1 ? BUSY_P0 : BUSY_P1;
`else
      state_nxt = BUSY_P0;
`endif
    end else if (p0_elig) begin
      state_nxt = BUSY_P0;
    end else if (p1_elig) begin
      state_nxt = BUSY_P1;
    end
  end

  // Access fields need no reset: every output path is gated by state_p1.
  always_ff @(posedge clk) begin
    if (state_nxt == BUSY_P0) begin
      acc_addr_p1  <= p0_addr;
      acc_wdata_p1 <= p0_wdata;
      acc_we_p1    <= p0_we;
    end else if (state_nxt == BUSY_P1) begin
      acc_addr_p1  <= p1_addr;
      acc_wdata_p1 <= p1_wdata;
      acc_we_p1    <= p1_we;
    end
  end

  // ---- stage p1: memory drive and acknowledge ----
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    p0_rdata  = '0;
    p1_rdata  = '0;
    case (state_p1)
      BUSY_P0: begin
        mem_addr  = acc_addr_p1;
        mem_wdata = acc_wdata_p1;
        mem_we    = acc_we_p1;
        p0_ack    = 1'b1;
        p0_rdata  = mem_rdata;
      end
      BUSY_P1: begin
        mem_addr  = acc_addr_p1;
        mem_wdata = acc_wdata_p1;
        mem_we    = acc_we_p1;
        p1_ack    = 1'b1;
        p1_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural 256x32 memory (negedge write, combinational read),
// vector table for directed sequences, hand-written reset corners, and a scoreboarded random phase.
module tb_dmem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              p0_req = 1'b0, p0_we = 1'b0;
  logic [ADDR_W-1:0] p0_addr = '0;
  logic [DATA_W-1:0] p0_wdata = '0;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;
  logic              p1_req = 1'b0, p1_we = 1'b0;
  logic [ADDR_W-1:0] p1_addr = '0;
  logic [DATA_W-1:0] p1_wdata = '0;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: preloaded with mem[i]=i, commits writes on the falling edge.
  logic [DATA_W-1:0] mem [256];
  logic preload = 1'b1;
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  typedef struct {
    logic        r0, w0;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic        r1, w1;
    logic [7:0]  a1;
    logic [31:0] d1;
    logic        ea0, ea1;
    logic [31:0] er0, er1;
    logic        ewe;
    logic [7:0]  eaddr;
    logic [31:0] ewd;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic [7:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [7:0] a1, logic [31:0] d1,
                              logic ea0, logic ea1, logic [31:0] er0, logic [31:0] er1,
                              logic ewe, logic [7:0] eaddr, logic [31:0] ewd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ea0 = ea0; v.ea1 = ea1; v.er0 = er0; v.er1 = er1;
    v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
    return v;
  endfunction

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] d;
  } acc_t;

  vec_t        vecs [21];
  acc_t        q0 [$];
  acc_t        q1 [$];
  logic [31:0] model [256];

  function automatic acc_t rnd_acc();
    acc_t a;
    a.we   = ($urandom_range(0, 2) == 0);
    a.addr = 8'(64 + $urandom_range(0, 15));
    a.d    = a.we ? $urandom : 32'h0;
    return a;
  endfunction

  initial begin
    acc_t e;
    int   wait0, wait1;

    // Vector table: each row is driven, one edge passes, then outputs are compared.
    vecs[0]  = mk(1,0,8'd1,0,  1,0,8'd2,0,  1,0,1,0,  0,8'd1,0);
    vecs[1]  = mk(0,0,8'd0,0,  1,0,8'd2,0,  0,1,0,2,  0,8'd2,0);
    vecs[2]  = mk(0,0,8'd0,0,  0,0,8'd0,0,  0,0,0,0,  0,8'd0,0);
    vecs[3]  = mk(1,0,8'd5,0,  0,0,8'd0,0,  1,0,5,0,  0,8'd5,0);
    vecs[4]  = mk(0,0,8'd0,0,  0,0,8'd0,0,  0,0,0,0,  0,8'd0,0);
    vecs[5]  = mk(0,0,8'd0,0,  1,1,8'd10,32'hDEADBEEF,  0,1,0,10,  1,8'd10,32'hDEADBEEF);
    vecs[6]  = mk(1,0,8'd10,0, 0,0,8'd0,0,  1,0,32'hDEADBEEF,0,  0,8'd10,0);
    vecs[7]  = mk(0,0,8'd0,0,  1,0,8'd4,0,  0,1,0,4,  0,8'd4,0);
    vecs[8]  = mk(0,0,8'd0,0,  0,0,8'd0,0,  0,0,0,0,  0,8'd0,0);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) vecs[9+k] = mk(1,0,8'd3,0, 1,0,8'd7,0, 1,0,3,0, 0,8'd3,0);
      else            vecs[9+k] = mk(1,0,8'd3,0, 1,0,8'd7,0, 0,1,0,7, 0,8'd7,0);
    end
    vecs[15] = mk(0,0,8'd0,0,  0,0,8'd0,0,  0,0,0,0,  0,8'd0,0);
    vecs[16] = mk(1,0,8'd6,0,  0,0,8'd0,0,  1,0,6,0,  0,8'd6,0);
    vecs[17] = mk(0,0,8'd0,0,  0,0,8'd0,0,  0,0,0,0,  0,8'd0,0);
`ifdef DMEM_ARB_RR_EN
    vecs[18] = mk(1,0,8'd8,0,  1,0,8'd9,0,  0,1,0,9,  0,8'd9,0);
    vecs[19] = mk(1,0,8'd8,0,  1,0,8'd9,0,  1,0,8,0,  0,8'd8,0);
`else
    vecs[18] = mk(1,0,8'd8,0,  1,0,8'd9,0,  1,0,8,0,  0,8'd8,0);
    vecs[19] = mk(1,0,8'd8,0,  1,0,8'd9,0,  0,1,0,9,  0,8'd9,0);
`endif
    vecs[20] = mk(0,0,8'd0,0,  0,0,8'd0,0,  0,0,0,0,  0,8'd0,0);

    // Reset held for 3 cycles with both ports requesting.
    drive(1,0,8'd1,0, 1,0,8'd2,0);
    @(negedge clk);
    #1 preload = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("rst%0d_p0_ack", i), p0_ack, 0);
      chk($sformatf("rst%0d_p1_ack", i), p1_ack, 0);
      chk($sformatf("rst%0d_mem_we", i), mem_we, 0);
      chk($sformatf("rst%0d_mem_addr", i), mem_addr, 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      tick;
      chk($sformatf("row%0d_p0_ack", i), p0_ack, vecs[i].ea0);
      chk($sformatf("row%0d_p1_ack", i), p1_ack, vecs[i].ea1);
      chk($sformatf("row%0d_p0_rdata", i), p0_rdata, vecs[i].er0);
      chk($sformatf("row%0d_p1_rdata", i), p1_rdata, vecs[i].er1);
      chk($sformatf("row%0d_mem_we", i), mem_we, vecs[i].ewe);
      chk($sformatf("row%0d_mem_addr", i), mem_addr, vecs[i].eaddr);
      chk($sformatf("row%0d_mem_wdata", i), mem_wdata, vecs[i].ewd);
    end

    // Reset dropped during a p1 write, before the falling edge: no write may land.
    drive(0,0,8'd0,0, 1,1,8'd20,32'd99);
    tick;
    chk("rstw_p1_ack", p1_ack, 1);
    chk("rstw_mem_we", mem_we, 1);
    chk("rstw_mem_addr", mem_addr, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_we_cleared", mem_we, 0);
    chk("rstw_ack_cleared", p1_ack, 0);
    chk("rstw_addr_cleared", mem_addr, 0);
    chk("rstw_rdata_cleared", p1_rdata, 0);
    drive(0,0,8'd0,0, 0,0,8'd0,0);
    tick;
    rst_n = 1'b1;
    drive(1,0,8'd20,0, 0,0,8'd0,0);
    tick;
    chk("rstw_read_ack", p0_ack, 1);
    chk("rstw_read_unchanged", p0_rdata, 20);
    drive(0,0,8'd0,0, 0,0,8'd0,0);
    tick;
    chk("rstw_idle_ack", p0_ack, 0);

    // Scoreboard phase: random traffic from both ports; expectations resolved at ack time.
    for (int i = 0; i < 256; i++) model[i] = 32'(i);
    model[10] = 32'hDEADBEEF;
    wait0 = 0;
    wait1 = 0;
    for (int cyc = 0; cyc < 310; cyc++) begin
      tick;
      chk("sb_single_ack", {31'd0, p0_ack & p1_ack}, 0);
      if (!p0_ack && !p1_ack) chk("sb_idle_we", mem_we, 0);

      if (p0_ack) begin
        if (q0.size() == 0) begin
          chk("sb_p0_unexpected_ack", p0_ack, 0);
        end else begin
          e = q0.pop_front();
          chk("sb_p0_we", mem_we, e.we);
          chk("sb_p0_addr", mem_addr, e.addr);
          if (e.we) begin
            chk("sb_p0_wdata", mem_wdata, e.d);
            model[e.addr] = e.d;
          end else begin
            chk("sb_p0_rdata", p0_rdata, model[e.addr]);
          end
        end
        p0_req = 1'b0;
        wait0 = 0;
      end else if (q0.size() != 0) begin
        wait0++;
        if (wait0 > 3) begin
          n_tests++; n_fail++;
          $display("FAIL sb_p0_timeout: no ack after %0d cycles, required within 3", wait0);
          void'(q0.pop_front());
          p0_req = 1'b0;
          wait0 = 0;
        end
      end

      if (p1_ack) begin
        if (q1.size() == 0) begin
          chk("sb_p1_unexpected_ack", p1_ack, 0);
        end else begin
          e = q1.pop_front();
          chk("sb_p1_we", mem_we, e.we);
          chk("sb_p1_addr", mem_addr, e.addr);
          if (e.we) begin
            chk("sb_p1_wdata", mem_wdata, e.d);
            model[e.addr] = e.d;
          end else begin
            chk("sb_p1_rdata", p1_rdata, model[e.addr]);
          end
        end
        p1_req = 1'b0;
        wait1 = 0;
      end else if (q1.size() != 0) begin
        wait1++;
        if (wait1 > 3) begin
          n_tests++; n_fail++;
          $display("FAIL sb_p1_timeout: no ack after %0d cycles, required within 3", wait1);
          void'(q1.pop_front());
          p1_req = 1'b0;
          wait1 = 0;
        end
      end

      if (cyc < 300 && q0.size() == 0 && $urandom_range(0, 3) != 0) begin
        e = rnd_acc();
        q0.push_back(e);
        p0_req = 1'b1; p0_we = e.we; p0_addr = e.addr; p0_wdata = e.d;
      end
      if (cyc < 300 && q1.size() == 0 && $urandom_range(0, 3) != 0) begin
        e = rnd_acc();
        q1.push_back(e);
        p1_req = 1'b1; p1_we = e.we; p1_addr = e.addr; p1_wdata = e.d;
      end
    end
    chk("sb_p0_drained", q0.size(), 0);
    chk("sb_p1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
